// File: rtl/slave_out_port.sv
// Bit-serial transmit stage: buffers parallel words in a small FIFO and, on a read
// instruction, streams burst_num+1 words LSB first using a valid/ready word handshake.
module slave_out_port #(
  parameter int unsigned DATA_LEN   = 8,
  parameter int unsigned BURST_LEN  = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           instruction,
  input  logic [BURST_LEN-1:0] burst_num,
  input  logic [DATA_LEN-1:0]  din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 tx_data,
  output logic                 slave_valid,
  input  logic                 master_ready,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = $clog2(DATA_LEN);
  localparam logic [1:0]  INSTR_READ = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD, HANDSHAKE, SHIFT, DONE} state_t;

  // ---------------- word FIFO ----------------
  logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                full, empty, push, pop;
  logic [DATA_LEN-1:0] head;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  // Ready comes from the registered count only, so a pop cannot open a slot for a same-cycle push.
  assign din_ready = !full;
  assign push      = din_valid && !full;
  assign head      = mem[rd_ptr];

  // NOTE: storage array has no reset; flushing is done by clearing pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- transmit FSM ----------------
  state_t               state, state_next;
  logic [DATA_LEN-1:0]  shift_reg, shift_reg_next;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
  logic [BURST_LEN-1:0] word_cnt, word_cnt_next;
  logic [BURST_LEN-1:0] burst_lim, burst_lim_next;
  logic                 tx_data_next, slave_valid_next, busy_next;

  // NOTE: state and datapath registers use non-blocking assignment only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      burst_lim   <= '0;
      tx_data     <= 1'b0;
      slave_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      shift_reg   <= shift_reg_next;
      bit_cnt     <= bit_cnt_next;
      word_cnt    <= word_cnt_next;
      burst_lim   <= burst_lim_next;
      tx_data     <= tx_data_next;
      slave_valid <= slave_valid_next;
      busy        <= busy_next;
    end
  end

  // NOTE: every signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_next       = state;
    shift_reg_next   = shift_reg;
    bit_cnt_next     = bit_cnt;
    word_cnt_next    = word_cnt;
    burst_lim_next   = burst_lim;
    tx_data_next     = tx_data;
    slave_valid_next = 1'b0;
    busy_next        = busy;
    pop              = 1'b0;

    unique case (state)
      IDLE: begin
        if (instruction == INSTR_READ) begin
          burst_lim_next = burst_num;
          word_cnt_next  = '0;
          busy_next      = 1'b1;
          state_next     = LOAD;
        end
      end

      LOAD: begin
        if (!empty) begin
          pop              = 1'b1;
          shift_reg_next   = head;
          tx_data_next     = head[0];
          slave_valid_next = 1'b1;
          state_next       = HANDSHAKE;
        end
      end

      HANDSHAKE: begin
        slave_valid_next = 1'b1;
        if (master_ready) begin
          // Bit 0 is taken by the master on this edge; present bit 1 next.
          tx_data_next     = shift_reg[1];
          shift_reg_next   = shift_reg >> 1;
          bit_cnt_next     = BIT_W'(1);
          slave_valid_next = 1'b0;
          state_next       = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_cnt != BIT_W'(DATA_LEN - 1)) begin
          tx_data_next   = shift_reg[1];
          shift_reg_next = shift_reg >> 1;
          bit_cnt_next   = bit_cnt + BIT_W'(1);
        end else begin
          bit_cnt_next = '0;
          // Equality compare lets burst_num = all-ones send 2^BURST_LEN words.
          if (word_cnt == burst_lim) begin
            state_next = DONE;
          end else begin
            word_cnt_next = word_cnt + BURST_LEN'(1);
            state_next    = LOAD;
          end
        end
      end

      DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign tx_done = (state == DONE);

endmodule

// File: doc/slave_out_port.md
Name: slave_out_port

Overview:
Bit-serial transmit stage on the slave side of the serial bus. It feeds the master input port directly. Parallel words arrive from slave-side logic over a valid/ready interface and are buffered in a small word FIFO. On a read instruction, the block sends burst_num+1 words, LSB first, one bit per clock, using the slave_valid/master_ready word handshake.

Parameters:
DATA_LEN, 8, bits per word
BURST_LEN, 12, width of burst_num and of the word counter
FIFO_DEPTH, 4, word FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
instruction  input  2  bus instruction; 2'b11 = read (start burst), other codes ignored
burst_num  input  BURST_LEN  words in burst minus one; sampled on start
din  input  DATA_LEN  parallel word to transmit
din_valid  input  1  din valid
din_ready  output  1  FIFO can accept a word
tx_data  output  1  serial data line to master rx_data
slave_valid  output  1  word-start valid to master
master_ready  input  1  master ready for next word
busy  output  1  burst in progress
tx_done  output  1  one-cycle pulse after the last bit of the burst

Behaviour:
- Reset: on reset_n low, immediately and regardless of state: FSM=IDLE, FIFO flushed (count 0), tx_data=0, slave_valid=0, busy=0, tx_done=0, counters 0. din_ready=1 after reset.
- FIFO: push when din_valid && din_ready; din_ready = !full (combinational from count). A pop while full does not free a slot in the same cycle. Push is allowed in any state, including IDLE. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOAD, HANDSHAKE, SHIFT, DONE.
- IDLE: if instruction==2'b11: latch burst_num into burst_lim, word_cnt<=0, busy<=1, go to LOAD. Any other instruction code: stay in IDLE.
- instruction is ignored in every state except IDLE.
- LOAD: if FIFO is not empty: pop the head into shift_reg, tx_data<=head[0], slave_valid<=1, go to HANDSHAKE. If FIFO is empty: stall in LOAD with slave_valid=0 and tx_data held; no timeout.
- HANDSHAKE: hold slave_valid=1 and tx_data=bit0. On the first rising edge with master_ready==1, the master samples bit0. On that same edge: tx_data<=shift_reg[1], bit_cnt<=1, slave_valid<=0, go to SHIFT.
- SHIFT: one bit per cycle. On each edge: if bit_cnt<DATA_LEN-1, tx_data<=shift_reg[bit_cnt+1] and bit_cnt++.
- SHIFT, last bit (bit_cnt==DATA_LEN-1, i.e. the final bit is being presented this cycle): bit_cnt<=0. If word_cnt==burst_lim, go to DONE; else word_cnt++ and go to LOAD.
- Word timing: a word occupies exactly DATA_LEN consecutive cycles on tx_data from the handshake edge. Minimum inter-word gap is 1 cycle (LOAD). slave_valid is never high during SHIFT, so no spurious handshake is possible.
- DONE: tx_done=1 for exactly one cycle, busy<=0, slave_valid=0, go to IDLE. tx_done is 0 in all other states.
- Width rules: word_cnt and burst_lim are BURST_LEN bits. Equality compare, so burst_num=2^BURST_LEN-1 yields 2^BURST_LEN words with no overflow. burst_num=0 yields one word.
- master_ready is ignored outside HANDSHAKE.
- Reset mid-burst aborts the burst; partially sent words are lost and no tx_done is issued.

Test Plan:
- Reset: assert reset_n=0 mid-SHIFT of a word -> same cycle: slave_valid=0, tx_data=0, busy=0, din_ready=1; after release the FSM is in IDLE and FIFO is empty.
- Single word: push 0xA5, instruction=11, burst_num=0, master_ready=1 -> slave_valid high one cycle; tx_data over 8 cycles = 1,0,1,0,0,1,0,1; tx_done pulses 1 cycle after the last bit; busy drops.
- Delayed ready: push 0x3C, start, hold master_ready=0 for 5 cycles -> slave_valid and tx_data=0 held 5+ cycles; on ready=1, bits 0,0,1,1,1,1,0,0 follow.
- Burst with underflow: burst_num=2, push 0x01, then push 0x02 and 0xFF after a 6-cycle gap -> LOAD stalls with slave_valid=0 during the gap; 3 words sent in order; one tx_done pulse.
- FIFO full: 4 pushes with no instruction -> din_ready=0 after the 4th; 5th push is not accepted; after one word is popped, din_ready=1 the following cycle.
- Instruction while busy: issue 11 during SHIFT -> ignored; word count equals the original burst_num+1.
